// File: rtl/trap_writeback_stage.sv
// trap_writeback_stage
//   Writeback stage plus trap/return control. Latches the MEM/WB register
//   and drives the register-file write port. Turns memory-stage faults and
//   IRET into flush, redirect and privilege changes. Owns the rm0..rm2 trap
//   registers and the vm_enable mode bit.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   stall_in, valid_in      MEM slot status (stalled / holds real instr)
//   wb_data_in, rd_in,
//   is_write_in, kill_wb_in writeback request from MEM
//   tlb_miss_in, tlb_fault_addr_in, tlb_fault_pc_in,
//   tlbwrite_priv_fault_in,
//   iret_taken_in, iret_priv_fault_in   event inputs
//   rm_sel_in / rm_value_out            MOVRM read port (combinational)
//   vm_enable                           1 = user mode with translation
//   rf_we, rf_waddr, rf_wdata           registered register-file write port
//   flush_out, redirect_valid,
//   redirect_pc                         pipeline control (combinational)
//   trap_active                         block is in HOLD
module trap_writeback_stage #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_2000,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        valid_in,
  input  logic [31:0] wb_data_in,
  input  logic [4:0]  rd_in,
  input  logic        is_write_in,
  input  logic        kill_wb_in,
  input  logic        tlb_miss_in,
  input  logic [31:0] tlb_fault_addr_in,
  input  logic [31:0] tlb_fault_pc_in,
  input  logic        tlbwrite_priv_fault_in,
  input  logic        iret_taken_in,
  input  logic        iret_priv_fault_in,
  input  logic [1:0]  rm_sel_in,
  output logic [31:0] rm_value_out,
  output logic        vm_enable,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush_out,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        trap_active
);

  typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;

  // HOLD lasts hold_cnt+1 cycles, so loading HOLD_CYCLES-1 gives exactly
  // HOLD_CYCLES cycles of flush after the event cycle.
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_TLB_MISS = 2'd1;
  localparam logic [1:0] CAUSE_TLBW     = 2'd2;
  localparam logic [1:0] CAUSE_IRET     = 2'd3;

  state_t      state, state_nxt;
  logic [3:0]  hold_cnt, hold_cnt_nxt;
  logic [31:0] rm0, rm1, rm2;

  logic        evt_ok;   // an event may be taken this cycle
  logic [1:0]  cause;    // highest-priority fault among the inputs
  logic        trap;     // fault taken this cycle
  logic        ret;      // IRET taken this cycle

  // ---------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------
  always_comb begin
    cause = CAUSE_NONE;
    if (tlb_miss_in)                 cause = CAUSE_TLB_MISS;
    else if (tlbwrite_priv_fault_in) cause = CAUSE_TLBW;
    else if (iret_priv_fault_in)     cause = CAUSE_IRET;
  end

  assign evt_ok = (state == S_RUN) && valid_in && !stall_in;
  assign trap   = evt_ok && (cause != CAUSE_NONE);
  // A fault always beats a simultaneous legal IRET.
  assign ret    = evt_ok && (cause == CAUSE_NONE) && iret_taken_in;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RUN;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      S_RUN: begin
        if (trap || ret) begin
          state_nxt    = S_HOLD;
          hold_cnt_nxt = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (hold_cnt == 4'd0) state_nxt    = S_RUN;
        else                  hold_cnt_nxt = hold_cnt - 4'd1;
      end
      default: begin
        state_nxt    = S_RUN;
        hold_cnt_nxt = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    trap_active    = (state == S_HOLD);
    flush_out      = (state == S_HOLD) || trap || ret;
    redirect_valid = trap || ret;
    redirect_pc    = 32'd0;
    if (trap)     redirect_pc = EXC_VECTOR;
    else if (ret) redirect_pc = rm0;
  end

  // ---------------------------------------------------------------------
  // Trap registers and mode bit
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rm0       <= 32'd0;
      rm1       <= 32'd0;
      rm2       <= 32'd0;
      vm_enable <= 1'b0;
    end else if (trap) begin
      rm0       <= tlb_fault_pc_in;
      rm1       <= (cause == CAUSE_TLB_MISS) ? tlb_fault_addr_in : 32'd0;
      rm2       <= {30'd0, cause};
      vm_enable <= 1'b0;
    end else if (ret) begin
      vm_enable <= 1'b1;
    end
  end

  always_comb begin
    rm_value_out = 32'd0;
    case (rm_sel_in)
      2'd0:    rm_value_out = rm0;
      2'd1:    rm_value_out = rm1;
      2'd2:    rm_value_out = rm2;
      default: rm_value_out = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------
  // MEM/WB register. Address and data follow MEM every edge; only the
  // enable is qualified, so a stalled instruction is a bubble until the
  // stall drops and is then written exactly once.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else begin
      rf_we    <= valid_in && is_write_in && !kill_wb_in && !stall_in &&
                  (state == S_RUN) && !trap && !ret;
      rf_waddr <= rd_in;
      rf_wdata <= wb_data_in;
    end
  end

endmodule

// File: tb/tb_trap_writeback_stage.sv
module tb_trap_writeback_stage;

  localparam logic [31:0] EXC_VEC = 32'h0000_2000;
  localparam int          HOLD_N  = 2;

  logic        clk = 1'b0;
  logic        reset, stall_in, valid_in, is_write_in, kill_wb_in;
  logic [31:0] wb_data_in, tlb_fault_addr_in, tlb_fault_pc_in;
  logic [4:0]  rd_in;
  logic        tlb_miss_in, tlbwrite_priv_fault_in, iret_taken_in, iret_priv_fault_in;
  logic [1:0]  rm_sel_in;
  logic [31:0] rm_value_out, rf_wdata, redirect_pc;
  logic        vm_enable, rf_we, flush_out, redirect_valid, trap_active;
  logic [4:0]  rf_waddr;

  always #5 clk = ~clk;

  trap_writeback_stage #(.EXC_VECTOR(EXC_VEC), .HOLD_CYCLES(HOLD_N)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .valid_in(valid_in),
    .wb_data_in(wb_data_in), .rd_in(rd_in), .is_write_in(is_write_in),
    .kill_wb_in(kill_wb_in), .tlb_miss_in(tlb_miss_in),
    .tlb_fault_addr_in(tlb_fault_addr_in), .tlb_fault_pc_in(tlb_fault_pc_in),
    .tlbwrite_priv_fault_in(tlbwrite_priv_fault_in), .iret_taken_in(iret_taken_in),
    .iret_priv_fault_in(iret_priv_fault_in), .rm_sel_in(rm_sel_in),
    .rm_value_out(rm_value_out), .vm_enable(vm_enable), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flush_out(flush_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_active(trap_active)
  );

  typedef struct {
    bit        rst, valid, stall, wr, kill, miss, tlbw, iret, iretp;
    bit [31:0] data, faddr, fpc;
    bit [4:0]  rd;
    bit [1:0]  sel;
  } stim_t;

  int nchk = 0, nfail = 0;

  // Reference model: architectural view of the block.
  int        flush_left = 0;   // cycles of post-event flush still owed
  bit [31:0] m_rm [3];
  bit        m_vm, m_we, known = 0;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s       = idle();
    s.rst   = ($urandom_range(0, 99) == 0);
    s.valid = ($urandom_range(0, 3) != 0);
    s.stall = ($urandom_range(0, 4) == 0);
    s.wr    = ($urandom_range(0, 3) != 0);
    s.kill  = ($urandom_range(0, 7) == 0);
    s.miss  = ($urandom_range(0, 9) == 0);
    s.tlbw  = ($urandom_range(0, 11) == 0);
    s.iret  = ($urandom_range(0, 7) == 0);
    s.iretp = ($urandom_range(0, 11) == 0);
    s.data  = $urandom;
    s.faddr = $urandom;
    s.fpc   = $urandom;
    s.rd    = 5'($urandom_range(0, 31));
    s.sel   = 2'($urandom_range(0, 3));
    return s;
  endfunction

  task automatic step(input stim_t s);
    int        cause;
    bit        ret, evt;
    bit [31:0] exp_pc, exp_rm;
    @(negedge clk);
    if (known) begin
      chk("rf_we", 32'(rf_we), 32'(m_we));
      chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk("rf_wdata", rf_wdata, m_wdata);
      chk("vm_enable", 32'(vm_enable), 32'(m_vm));
    end
    reset = s.rst; valid_in = s.valid; stall_in = s.stall; is_write_in = s.wr;
    kill_wb_in = s.kill; tlb_miss_in = s.miss; tlbwrite_priv_fault_in = s.tlbw;
    iret_taken_in = s.iret; iret_priv_fault_in = s.iretp; wb_data_in = s.data;
    tlb_fault_addr_in = s.faddr; tlb_fault_pc_in = s.fpc; rd_in = s.rd; rm_sel_in = s.sel;
    #1;
    cause = 0; ret = 0;
    if (flush_left == 0 && s.valid && !s.stall) begin
      if (s.miss)       cause = 1;
      else if (s.tlbw)  cause = 2;
      else if (s.iretp) cause = 3;
      else if (s.iret)  ret = 1;
    end
    evt    = (cause != 0) || ret;
    exp_pc = (cause != 0) ? EXC_VEC : (ret ? m_rm[0] : 32'd0);
    exp_rm = (s.sel < 3) ? m_rm[s.sel] : 32'd0;
    if (known) begin
      chk("trap_active", 32'(trap_active), 32'(flush_left > 0));
      chk("flush_out", 32'(flush_out), 32'(flush_left > 0 || evt));
      chk("redirect_valid", 32'(redirect_valid), 32'(evt));
      chk("redirect_pc", redirect_pc, exp_pc);
      chk("rm_value", rm_value_out, exp_rm);
    end
    // state after the coming edge
    m_we    = s.valid && s.wr && !s.kill && !s.stall && flush_left == 0 && !evt;
    m_waddr = s.rd;
    m_wdata = s.data;
    if (evt) begin
      flush_left = HOLD_N;
      if (cause != 0) begin
        m_rm[0] = s.fpc;
        m_rm[1] = (cause == 1) ? s.faddr : 32'd0;
        m_rm[2] = 32'(cause);
        m_vm    = 0;
      end else m_vm = 1;
    end else if (flush_left > 0) flush_left--;
    if (s.rst) begin
      flush_left = 0; m_rm = '{default: 0}; m_vm = 0;
      m_we = 0; m_waddr = 0; m_wdata = 0; known = 1;
    end
  endtask

  task automatic idle_sel(input int n, input bit [1:0] sel);
    stim_t s;
    s = idle(); s.sel = sel;
    for (int i = 0; i < n; i++) step(s);
  endtask

  initial begin
    stim_t s;
    reset = 1; stall_in = 0; valid_in = 0; is_write_in = 0; kill_wb_in = 0;
    tlb_miss_in = 0; tlbwrite_priv_fault_in = 0; iret_taken_in = 0;
    iret_priv_fault_in = 0; wb_data_in = 0; rd_in = 0; rm_sel_in = 0;
    tlb_fault_addr_in = 0; tlb_fault_pc_in = 0;

    // reset
    s = idle(); s.rst = 1; step(s); step(s);
    idle_sel(1, 0); idle_sel(1, 1); idle_sel(1, 2);

    // normal write
    s = idle(); s.valid = 1; s.wr = 1; s.rd = 5; s.data = 32'hDEAD_BEEF; step(s);
    idle_sel(1, 0);
    // stall 3 cycles, then release
    s.stall = 1; step(s); step(s); step(s);
    s.stall = 0; step(s);
    idle_sel(2, 0);

    // enter user mode via IRET to rm0, then TLB miss
    s = idle(); s.valid = 1; s.iret = 1; step(s);
    idle_sel(3, 0);
    s = idle(); s.valid = 1; s.wr = 1; s.rd = 7; s.miss = 1;
    s.fpc = 32'h100; s.faddr = 32'h8000_0040; step(s);
    idle_sel(1, 0); idle_sel(1, 1); idle_sel(1, 2); idle_sel(1, 3);

    // IRET round trip, second pulse during HOLD ignored
    s = idle(); s.valid = 1; s.iret = 1; step(s);
    step(s); step(s);
    idle_sel(1, 0);

    // priority: tlbwrite fault beats IRET
    s = idle(); s.valid = 1; s.tlbw = 1; s.iret = 1; s.fpc = 32'h340; s.faddr = 32'h55; step(s);
    idle_sel(1, 2); idle_sel(1, 1); idle_sel(1, 0);
    s = idle(); s.valid = 1; s.iretp = 1; s.fpc = 32'h480; step(s);
    idle_sel(3, 2);

    // reset in the middle of HOLD
    s = idle(); s.valid = 1; s.miss = 1; s.fpc = 32'h900; s.faddr = 32'h1234; step(s);
    s = idle(); s.rst = 1; step(s);
    idle_sel(1, 0); idle_sel(1, 2);

    // randomized run
    for (int i = 0; i < 3000; i++) step(rnd());
    idle_sel(4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/trap_writeback_stage.md
# trap_writeback_stage

Writeback stage with the trap/return control unit, directly downstream of the memory stage. It latches the MEM/WB pipeline register and drives the register-file write port. It turns the memory stage's fault and IRET indications into pipeline flushes, PC redirects and privilege-mode changes. It owns the rm0–rm2 trap registers, the `vm_enable` mode bit, and supplies `rm_value` back to the memory stage for MOVRM.

## Interface
- `EXC_VECTOR`, default 32'h0000_2000: trap handler entry PC.
- `HOLD_CYCLES`, default 2: cycles after a redirect during which new traps are ignored and register-file writes are suppressed (range 1–15).

Clocking: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `stall_in`  in  1  memory-stage `stall_req`; the MEM instruction has not completed
- `valid_in`  in  1  MEM slot holds a real instruction
- `wb_data_in`  in  32  memory-stage `wb_data_out`
- `rd_in`  in  5  destination register
- `is_write_in`  in  1  instruction writes the register file
- `kill_wb_in`  in  1  memory-stage `kill_wb`
- `tlb_miss_in`  in  1  dTLB miss
- `tlb_fault_addr_in`  in  32  faulting virtual address
- `tlb_fault_pc_in`  in  32  PC of the MEM instruction
- `tlbwrite_priv_fault_in`  in  1  TLBWRITE issued in user mode
- `iret_taken_in`  in  1  legal IRET
- `iret_priv_fault_in`  in  1  IRET issued in user mode
- `rm_sel_in`  in  2  rm register read select (0–2; 3 reads 0)
- `rm_value_out`  out  32  combinational read of the selected rm register
- `vm_enable`  out  1  1 = user mode with translation; reset 0
- `rf_we`  out  1  register-file write enable (registered); reset 0
- `rf_waddr`  out  5  write address (registered); reset 0
- `rf_wdata`  out  32  write data (registered); reset 0
- `flush_out`  out  1  squash IF/ID/EX/MEM contents at this edge
- `redirect_valid`  out  1  fetch loads `redirect_pc` at this edge
- `redirect_pc`  out  32  new fetch PC; 0 when `redirect_valid` is 0
- `trap_active`  out  1  state is HOLD

## Operation
- State machine has two states, RUN and HOLD. A 4-bit `hold_cnt` counter runs in HOLD. Reset puts the block in RUN with `hold_cnt`=0, rm0=rm1=rm2=0 and `vm_enable`=0.
- An event is evaluated only when all of these hold: state is RUN, `valid_in`=1 and `stall_in`=0.
- Event priority, highest first; the first match wins:
  - `tlb_miss_in`: cause 1.
  - `tlbwrite_priv_fault_in`: cause 2.
  - `iret_priv_fault_in`: cause 3.
  - `iret_taken_in`: return.
- Trap (cause 1–3):
  - Combinationally in the same cycle: `flush_out`=1, `redirect_valid`=1, `redirect_pc`=`EXC_VECTOR`.
  - At the clock edge: rm0←`tlb_fault_pc_in`; rm1←`tlb_fault_addr_in` for cause 1, otherwise 0; rm2←cause; `vm_enable`←0; state←HOLD; `hold_cnt`←`HOLD_CYCLES`-1.
- Return (IRET):
  - Combinationally: `flush_out`=1, `redirect_valid`=1, `redirect_pc`=rm0.
  - At the edge: `vm_enable`←1, state←HOLD, `hold_cnt` loaded as for a trap. rm registers are unchanged.
- HOLD state:
  - `trap_active`=1, `flush_out`=1, `redirect_valid`=0.
  - `hold_cnt` decrements each cycle. At 0 the state returns to RUN on the next edge.
  - All event inputs are ignored.
- MEM/WB register, updated every edge:
  - `rf_waddr`←`rd_in`, `rf_wdata`←`wb_data_in`.
  - `rf_we`←`valid_in` & `is_write_in` & !`kill_wb_in` & !`stall_in` & (state==RUN) & !(any event this cycle).
  - A stalled instruction therefore produces a bubble, and is written exactly once when the stall drops.
  - A write with `rd_in`=0 is still presented on the port; the register file discards it.
- Simultaneous trap and IRET inputs: the trap wins. `vm_enable` ends at 0 and rm0 takes the fault PC.
- A reset in the middle of HOLD returns the block to RUN immediately, with all outputs at their reset values.

## Timing
- Register-file write latency is 1 cycle: MEM result in cycle N appears on `rf_we`/`rf_wdata` in cycle N+1.
- `flush_out` and `redirect_valid` are combinational in the event cycle N:
  - The younger instruction in MEM at cycle N+1 is already squashed.
  - `flush_out` remains high during cycles N+1 through N+`HOLD_CYCLES`.
  - It is 0 from cycle N+`HOLD_CYCLES`+1.
- rm0–rm2 and `vm_enable` are visible from cycle N+1.
- `rm_value_out` is purely combinational; a MOVRM in cycle N+1 reads the new rm2.
- While `stall_in`=1, only `rf_we` changes (held 0). No event is taken, and the rm registers and `vm_enable` are unchanged.

## Test plan
- **Reset:** hold `reset` 2 cycles → `rf_we`=0, `vm_enable`=0, rm0–rm2=0, `flush_out`=0, `trap_active`=0.
- **Normal write:** `valid_in`=1, `is_write_in`=1, `rd_in`=5, `wb_data_in`=32'hDEAD_BEEF → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=32'hDEAD_BEEF.
- **Stall then release:** same write with `stall_in`=1 for 3 cycles then 0 → `rf_we`=0 for 3 cycles, then exactly one write.
- **TLB miss:** with `vm_enable`=1, `tlb_miss_in`=1, `tlb_fault_pc_in`=32'h100, `tlb_fault_addr_in`=32'h8000_0040 →
  - same cycle: `redirect_pc`=32'h2000 and `flush_out`=1;
  - next cycle: rm0=32'h100, rm1=32'h8000_0040, rm2=1, `vm_enable`=0;
  - `flush_out` high for 2 more cycles; `rf_we`=0 throughout.
- **IRET round trip:** after the TLB-miss case, `iret_taken_in`=1 → `redirect_pc`=32'h100, `vm_enable`=1 next cycle. A second `iret_taken_in` pulse during HOLD is ignored.
- **Priority and privilege:** `tlbwrite_priv_fault_in` and `iret_taken_in` in the same cycle → rm2=2, rm1=0, `vm_enable`=0. `iret_priv_fault_in` alone → rm2=3.
